friscv_inst_prefetch: RTL and testbench
=======================================

# friscv_inst_prefetch

Parametrised instruction fetch front-end placed between the instruction memory interface and the control unit of the friscv core. It replaces the single-request, single-instruction fetch of the RV32I core with a prefetch queue of configurable depth. It keeps fetching sequential instructions while the control unit stalls, and supports a redirect (jump/branch) that flushes queued instructions and discards any in-flight response.

## Interface
- `INST_ADDRW`, default 16: instruction address width.
- `XLEN`, default 32: instruction/data width.
- `BOOT_ADDR`, default 0: first fetch address after reset.
- `DEPTH`, default 4: prefetch queue depth in instructions; must be a power of two and ≥ 2.
- `aclk`  in  1: clock.
- `aresetn`  in  1: asynchronous active-low reset.
- `srst`  in  1: synchronous active-high reset; same effect as `aresetn`.
- `inst_en`  out  1: memory request; held high with `inst_addr` stable until `inst_ready`.
- `inst_addr`  out  INST_ADDRW: request byte address; always 4-byte aligned.
- `inst_rdata`  in  XLEN: returned instruction; valid when `inst_en & inst_ready`.
- `inst_ready`  in  1: memory completion strobe.
- `fetch_valid`  out  1: queue head holds a valid instruction.
- `fetch_instr`  out  XLEN: head instruction.
- `fetch_pc`  out  INST_ADDRW: address of the head instruction.
- `fetch_ready`  in  1: control unit pops the head when `fetch_valid & fetch_ready`.
- `jump_valid`  in  1: redirect strobe, one cycle.
- `jump_addr`  in  INST_ADDRW: redirect target; bits [1:0] are ignored (forced to 0).
- `flush_cnt`  out  32: number of redirects taken (stats).
- `stall_cnt`  out  32: cycles with `fetch_valid=0` and no redirect pending (stats).

## Operation
- State machine: IDLE (no request), FETCH (request in flight), DISCARD (in-flight request belongs to a flushed stream).
- Issue rule: a request is issued when `count_next < DEPTH`. `count_next` is the queue occupancy after this cycle's push/pop.
- On completion in FETCH: push {`pc`, `inst_rdata`}, then `pc <= pc+4`, wrapping modulo 2^INST_ADDRW. If the issue rule holds, the next request follows back-to-back (`inst_en` stays high and the address advances the next cycle). Otherwise go to IDLE.
- IDLE → FETCH as soon as the issue rule holds.
- Redirect: the queue empties, `pc <= {jump_addr[INST_ADDRW-1:2],2'b00}`, and `stall_cnt`/`flush_cnt` update.
  - From IDLE, or from FETCH completing in the same cycle: go to FETCH at the new address next cycle. Returned data in that cycle is dropped.
  - From FETCH not completing: go to DISCARD. Keep `inst_en`/`inst_addr` unchanged until `inst_ready`, drop the data, then go to FETCH at the new `pc`.
- A redirect in DISCARD overwrites the target `pc` only.
- `fetch_valid & fetch_ready` with `jump_valid` in the same cycle: the pop is accepted, then the flush applies.
- Push and pop in the same cycle with a full queue is legal; occupancy is unchanged.

## Timing
- Reset values:
  - `inst_en=0`, `inst_addr=BOOT_ADDR`
  - `fetch_valid=0`, `fetch_instr=0`, `fetch_pc=0`
  - counters 0, state IDLE, queue empty.
- First `inst_en` is asserted on the first clock edge after reset release.
- Fetch latency: completion at cycle N gives `fetch_valid=1` at N+1 (registered queue output).
- Redirect at cycle J:
  - `fetch_valid=0` from J+1.
  - `inst_en` with the new address at J+1 if nothing is in flight; otherwise one cycle after the in-flight `inst_ready`.
- Reset mid-request drops the request immediately; the memory must tolerate a withdrawn `inst_en`.
- Sustained throughput is 1 instruction/cycle with a zero-wait memory and `fetch_ready=1`.

## Configuration
- `FRISCV_PREFETCH_STATS_EN` defined: `flush_cnt` and `stall_cnt` are implemented as saturating 32-bit counters.
- Not defined: both outputs are tied to 0 and no counter logic is synthesised.

## Structure
- `friscv_h.sv` holds:
  - the state typedef (IDLE/FETCH/DISCARD);
  - the queue entry width constant `INST_ADDRW+XLEN` as a macro.
- Sub-module `friscv_scfifo`: synchronous FIFO (`DEPTH`, `WIDTH`) with a registered output, a flush input, and a `count` output.

## Test plan
- Reset release with zero-wait memory and `fetch_ready=1`: addresses 0,4,8,… are requested back-to-back; `fetch_pc` follows 0,4,8,… one cycle behind.
- `fetch_ready=0`, `DEPTH=4`: exactly 4 requests are issued, then `inst_en=0`. One pop causes a new request at the next address (0x10).
- Redirect to 0x123 while a request to 0x8 waits 3 cycles:
  - the 0x8 data is dropped;
  - the next request is 0x120;
  - `flush_cnt=1` (with the macro).
- `jump_valid` and `inst_ready` in the same cycle: no push; `inst_addr` equals the jump target next cycle.
- `pc` at 0xFFFC with `INST_ADDRW=16`: the next request wraps to 0x0000.
- `aresetn` asserted mid-FETCH: all outputs return to their reset values; the first request after release is `BOOT_ADDR`.

Source files
------------

// File: rtl/friscv_h.sv
// Shared definitions for the friscv instruction prefetch front-end:
// the fetch state type and the queue entry width macro ({pc, instr}).
`ifndef FRISCV_H
`define FRISCV_H

`define FRISCV_PREFETCH_ENTRY_W(aw, xw) ((aw) + (xw))

package friscv_h_pkg;

  // state      | meaning
  // ST_IDLE    | no request outstanding
  // ST_FETCH   | request in flight, its data will be queued
  // ST_DISCARD | request in flight belongs to a flushed stream, data dropped
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } prefetch_state_t;

endpackage

`endif

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO with registered head output, synchronous flush and
// occupancy count. DEPTH must be a power of two >= 2.
module friscv_scfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [PW:0]      cnt_after_pop;
  logic             do_pop;

  assign do_pop        = pop & out_valid;
  assign rd_next       = rd_ptr + PW'(do_pop);
  assign cnt_after_pop = count - (PW+1)'(do_pop);

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and the registered head (next head computed ahead).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (srst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      count  <= cnt_after_pop + (PW+1)'(push);
      if (cnt_after_pop != '0) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_next];
      end else if (push) begin
        out_valid <= 1'b1;
        out_data  <= wdata;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/friscv_inst_prefetch.sv
// Instruction prefetch front-end: keeps a queue of sequential instructions
// ahead of the control unit and handles redirects by flushing the queue and
// discarding any in-flight response.
// Optional: define FRISCV_PREFETCH_STATS_EN to implement the saturating
// flush_cnt / stall_cnt statistics counters; otherwise both read 0.
module friscv_inst_prefetch
  import friscv_h_pkg::*;
#(
  parameter int INST_ADDRW = 16,
  parameter int XLEN       = 32,
  parameter int BOOT_ADDR  = 0,
  parameter int DEPTH      = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  output logic                  inst_en,
  output logic [INST_ADDRW-1:0] inst_addr,
  input  logic [XLEN-1:0]       inst_rdata,
  input  logic                  inst_ready,
  output logic                  fetch_valid,
  output logic [XLEN-1:0]       fetch_instr,
  output logic [INST_ADDRW-1:0] fetch_pc,
  input  logic                  fetch_ready,
  input  logic                  jump_valid,
  input  logic [INST_ADDRW-1:0] jump_addr,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           stall_cnt
);

  localparam int ENTRY_W = `FRISCV_PREFETCH_ENTRY_W(INST_ADDRW, XLEN);
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam logic [INST_ADDRW-1:0] BOOT = INST_ADDRW'(BOOT_ADDR);

  prefetch_state_t       state;
  logic [INST_ADDRW-1:0] pc;
  logic [INST_ADDRW-1:0] pc_inc;
  logic [INST_ADDRW-1:0] jump_tgt;
  logic [ENTRY_W-1:0]    q_data;
  logic [CW-1:0]         q_count;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  pop;
  logic                  issue;

  assign jump_tgt   = jump_addr & ~INST_ADDRW'(3);
  assign pc_inc     = pc + INST_ADDRW'(4);
  assign push       = (state == ST_FETCH) & inst_ready & ~jump_valid;
  assign pop        = fetch_valid & fetch_ready;
  assign count_next = q_count + CW'(push) - CW'(pop);
  assign issue      = count_next < CW'(DEPTH);

  friscv_scfifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .flush     (jump_valid),
    .push      (push),
    .wdata     ({pc, inst_rdata}),
    .pop       (pop),
    .out_valid (fetch_valid),
    .out_data  (q_data),
    .count     (q_count)
  );

  assign fetch_pc    = q_data[ENTRY_W-1:XLEN];
  assign fetch_instr = q_data[XLEN-1:0];

  // Fetch sequencer: request issue, back-to-back advance, redirect/discard.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      pc        <= BOOT;
      inst_en   <= 1'b0;
      inst_addr <= BOOT;
    end else if (srst) begin
      state     <= ST_IDLE;
      pc        <= BOOT;
      inst_en   <= 1'b0;
      inst_addr <= BOOT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jump_valid) begin
            pc        <= jump_tgt;
            inst_addr <= jump_tgt;
            inst_en   <= 1'b1;
            state     <= ST_FETCH;
          end else if (issue) begin
            inst_addr <= pc;
            inst_en   <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (inst_ready) begin
            if (jump_valid) begin
              pc        <= jump_tgt;
              inst_addr <= jump_tgt;
            end else begin
              pc <= pc_inc;
              if (issue) begin
                inst_addr <= pc_inc;
              end else begin
                inst_en <= 1'b0;
                state   <= ST_IDLE;
              end
            end
          end else if (jump_valid) begin
            pc    <= jump_tgt;
            state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (jump_valid) pc <= jump_tgt;
          if (inst_ready) begin
            inst_addr <= jump_valid ? jump_tgt : pc;
            state     <= ST_FETCH;
          end
        end
        default: begin
          state   <= ST_IDLE;
          inst_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRISCV_PREFETCH_STATS_EN
  logic [31:0] flush_q;
  logic [31:0] stall_q;

  // Saturating redirect and starvation counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      flush_q <= '0;
      stall_q <= '0;
    end else if (srst) begin
      flush_q <= '0;
      stall_q <= '0;
    end else begin
      if (jump_valid && flush_q != '1) flush_q <= flush_q + 32'd1;
      if (!fetch_valid && !jump_valid && state != ST_DISCARD && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign flush_cnt = flush_q;
  assign stall_cnt = stall_q;
`else
  assign flush_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_friscv_inst_prefetch.sv
module tb_friscv_inst_prefetch;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        srst = 1'b0;
  logic        inst_en;
  logic [15:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [15:0] fetch_pc;
  logic        fetch_ready = 1'b0;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_addr = '0;
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt;

  logic mem_auto = 1'b1;
  logic ready_man = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FRISCV_PREFETCH_STATS_EN
  logic stats_on = 1'b1;
`else
  logic stats_on = 1'b0;
`endif

  always #5 aclk = ~aclk;

  assign inst_rdata = {16'hC0DE, inst_addr};
  assign inst_ready = mem_auto ? inst_en : ready_man;

  friscv_inst_prefetch dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .srst        (srst),
    .inst_en     (inst_en),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_ready  (inst_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .flush_cnt   (flush_cnt),
    .stall_cnt   (stall_cnt)
  );

  task automatic do_reset(input logic fr, input logic auto);
    aresetn     = 1'b0;
    srst        = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = '0;
    fetch_ready = fr;
    mem_auto    = auto;
    ready_man   = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge aclk);
    n_cmp++; if (inst_en !== 1'b0) begin n_err++; $display("FAIL rst_inst_en got=%b exp=0", inst_en); end
    n_cmp++; if (inst_addr !== 16'h0) begin n_err++; $display("FAIL rst_inst_addr got=%h exp=0000", inst_addr); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_fetch_valid got=%b exp=0", fetch_valid); end
    n_cmp++; if (fetch_instr !== 32'h0) begin n_err++; $display("FAIL rst_fetch_instr got=%h exp=0", fetch_instr); end
    n_cmp++; if (fetch_pc !== 16'h0) begin n_err++; $display("FAIL rst_fetch_pc got=%h exp=0", fetch_pc); end
    n_cmp++; if (flush_cnt !== 32'h0) begin n_err++; $display("FAIL rst_flush_cnt got=%0d exp=0", flush_cnt); end
    n_cmp++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_stream;
    logic [15:0] exp_pc;
    do_reset(1'b1, 1'b1);
    @(negedge aclk);
    n_cmp++; if (inst_en !== 1'b1 || inst_addr !== 16'h0) begin
      n_err++; $display("FAIL stream_first_req got en=%b addr=%h exp en=1 addr=0000", inst_en, inst_addr);
    end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid got=%b exp=0", fetch_valid); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge aclk);
      exp_pc = 16'(4 * (i - 1));
      n_cmp++; if (inst_addr !== 16'(4 * i)) begin
        n_err++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, inst_addr, 16'(4 * i));
      end
      n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== exp_pc || fetch_instr !== {16'hC0DE, exp_pc}) begin
        n_err++; $display("FAIL stream_head[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                          i, fetch_valid, fetch_pc, fetch_instr, exp_pc, {16'hC0DE, exp_pc});
      end
    end
    n_cmp++; if (stall_cnt !== (stats_on ? 32'd2 : 32'd0)) begin
      n_err++; $display("FAIL stream_stall_cnt got=%0d exp=%0d", stall_cnt, stats_on ? 2 : 0);
    end
  endtask

  task automatic test_backpressure;
    int nreq = 0;
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (inst_en) nreq++;
    end
    n_cmp++; if (nreq != 4) begin n_err++; $display("FAIL bp_req_count got=%0d exp=4", nreq); end
    n_cmp++; if (inst_en !== 1'b0) begin n_err++; $display("FAIL bp_idle_en got=%b exp=0", inst_en); end
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h0) begin
      n_err++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0000", fetch_valid, fetch_pc);
    end
    fetch_ready = 1'b1;
    @(negedge aclk);
    fetch_ready = 1'b0;
    n_cmp++; if (inst_en !== 1'b1 || inst_addr !== 16'h0010) begin
      n_err++; $display("FAIL bp_refill_req got en=%b addr=%h exp en=1 addr=0010", inst_en, inst_addr);
    end
    n_cmp++; if (fetch_pc !== 16'h0004) begin n_err++; $display("FAIL bp_after_pop_pc got=%h exp=0004", fetch_pc); end
  endtask

  task automatic test_redirect_wait;
    do_reset(1'b1, 1'b0);
    @(negedge aclk); ready_man = 1'b1;
    @(negedge aclk); ready_man = 1'b1;
    @(negedge aclk);
    n_cmp++; if (inst_addr !== 16'h0008) begin n_err++; $display("FAIL rd_pre_addr got=%h exp=0008", inst_addr); end
    ready_man = 1'b0; jump_valid = 1'b1; jump_addr = 16'h0123;
    @(negedge aclk);
    jump_valid = 1'b0;
    n_cmp++; if (inst_en !== 1'b1 || inst_addr !== 16'h0008) begin
      n_err++; $display("FAIL rd_hold got en=%b addr=%h exp en=1 addr=0008", inst_en, inst_addr);
    end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rd_flushed got=%b exp=0", fetch_valid); end
    @(negedge aclk); ready_man = 1'b1;
    @(negedge aclk);
    n_cmp++; if (inst_en !== 1'b1 || inst_addr !== 16'h0120) begin
      n_err++; $display("FAIL rd_new_req got en=%b addr=%h exp en=1 addr=0120", inst_en, inst_addr);
    end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rd_drop got v=%b pc=%h exp v=0", fetch_valid, fetch_pc); end
    n_cmp++; if (flush_cnt !== (stats_on ? 32'd1 : 32'd0)) begin
      n_err++; $display("FAIL rd_flush_cnt got=%0d exp=%0d", flush_cnt, stats_on ? 1 : 0);
    end
    @(negedge aclk);
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h0120 || fetch_instr !== 32'hC0DE0120) begin
      n_err++; $display("FAIL rd_new_head got v=%b pc=%h ins=%h exp v=1 pc=0120 ins=c0de0120",
                        fetch_valid, fetch_pc, fetch_instr);
    end
  endtask

  task automatic test_jump_same_cycle;
    jump_valid = 1'b1; jump_addr = 16'h0302; ready_man = 1'b1;
    @(negedge aclk);
    jump_valid = 1'b0;
    n_cmp++; if (inst_addr !== 16'h0300 || inst_en !== 1'b1) begin
      n_err++; $display("FAIL js_addr got en=%b addr=%h exp en=1 addr=0300", inst_en, inst_addr);
    end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL js_no_push got=%b exp=0", fetch_valid); end
    @(negedge aclk);
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h0300) begin
      n_err++; $display("FAIL js_head got v=%b pc=%h exp v=1 pc=0300", fetch_valid, fetch_pc);
    end
    n_cmp++; if (flush_cnt !== (stats_on ? 32'd2 : 32'd0)) begin
      n_err++; $display("FAIL js_flush_cnt got=%0d exp=%0d", flush_cnt, stats_on ? 2 : 0);
    end
  endtask

  task automatic test_wrap;
    jump_valid = 1'b1; jump_addr = 16'hFFFE; ready_man = 1'b1;
    @(negedge aclk);
    jump_valid = 1'b0;
    n_cmp++; if (inst_addr !== 16'hFFFC) begin n_err++; $display("FAIL wrap_top got=%h exp=fffc", inst_addr); end
    @(negedge aclk);
    n_cmp++; if (inst_addr !== 16'h0000 || fetch_pc !== 16'hFFFC) begin
      n_err++; $display("FAIL wrap_next got addr=%h pc=%h exp addr=0000 pc=fffc", inst_addr, fetch_pc);
    end
    @(negedge aclk);
    n_cmp++; if (fetch_pc !== 16'h0000 || fetch_instr !== 32'hC0DE0000) begin
      n_err++; $display("FAIL wrap_head got pc=%h ins=%h exp pc=0000 ins=c0de0000", fetch_pc, fetch_instr);
    end
  endtask

  task automatic test_srst;
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    n_cmp++; if (inst_en !== 1'b0 || inst_addr !== 16'h0 || fetch_valid !== 1'b0 || flush_cnt !== 32'h0) begin
      n_err++; $display("FAIL srst_state got en=%b addr=%h v=%b flush=%0d exp en=0 addr=0000 v=0 flush=0",
                        inst_en, inst_addr, fetch_valid, flush_cnt);
    end
    ready_man = 1'b0;
    @(negedge aclk);
    n_cmp++; if (inst_en !== 1'b1 || inst_addr !== 16'h0) begin
      n_err++; $display("FAIL srst_restart got en=%b addr=%h exp en=1 addr=0000", inst_en, inst_addr);
    end
  endtask

  task automatic test_reset_mid;
    repeat (2) @(negedge aclk);
    n_cmp++; if (inst_en !== 1'b1) begin n_err++; $display("FAIL rm_pending got=%b exp=1", inst_en); end
    #2 aresetn = 1'b0;
    #1;
    n_cmp++; if (inst_en !== 1'b0 || inst_addr !== 16'h0 || fetch_valid !== 1'b0 ||
                 fetch_pc !== 16'h0 || fetch_instr !== 32'h0 || stall_cnt !== 32'h0) begin
      n_err++; $display("FAIL rm_async got en=%b addr=%h v=%b pc=%h ins=%h stall=%0d exp all zero",
                        inst_en, inst_addr, fetch_valid, fetch_pc, fetch_instr, stall_cnt);
    end
    @(negedge aclk);
    aresetn = 1'b1; mem_auto = 1'b1; fetch_ready = 1'b1;
    @(negedge aclk);
    n_cmp++; if (inst_en !== 1'b1 || inst_addr !== 16'h0) begin
      n_err++; $display("FAIL rm_boot_req got en=%b addr=%h exp en=1 addr=0000", inst_en, inst_addr);
    end
    @(negedge aclk);
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h0) begin
      n_err++; $display("FAIL rm_boot_head got v=%b pc=%h exp v=1 pc=0000", fetch_valid, fetch_pc);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_wait;
    test_jump_same_cycle;
    test_wrap;
    test_srst;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
